// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that funnels N_PORTS client request
// and write-data channels onto one downstream memory port and routes
// responses back by the port index carried in the upper tag bits.
// Optional feature macro: MEM_ARB_STATS_EN enables the per-port grant counters;
// without it stat_grants is tied to zero.
module mem_port_arbiter #(
    parameter int N_PORTS   = 2,
    parameter int IDX_BITS  = 1,
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int TAG_BITS  = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_PORTS-1:0]                c_req_valid,
    input  logic [N_PORTS-1:0]                c_req_rw,
    input  logic [N_PORTS*ADDR_BITS-1:0]      c_req_addr,
    input  logic [N_PORTS*TAG_BITS-1:0]       c_req_tag,
    output logic [N_PORTS-1:0]                c_req_ready,
    input  logic [N_PORTS-1:0]                c_req_data_valid,
    input  logic [N_PORTS*DATA_BITS-1:0]      c_req_data_bits,
    input  logic [N_PORTS*DATA_BITS/8-1:0]    c_req_data_mask,
    output logic [N_PORTS-1:0]                c_req_data_ready,
    output logic [N_PORTS-1:0]                c_resp_valid,
    output logic [TAG_BITS-1:0]               c_resp_tag,
    output logic [DATA_BITS-1:0]              c_resp_data,
    output logic                              mem_req_valid,
    output logic                              mem_req_rw,
    output logic [ADDR_BITS-1:0]              mem_req_addr,
    output logic [IDX_BITS+TAG_BITS-1:0]      mem_req_tag,
    input  logic                              mem_req_ready,
    output logic                              mem_req_data_valid,
    output logic [DATA_BITS-1:0]              mem_req_data_bits,
    output logic [DATA_BITS/8-1:0]            mem_req_data_mask,
    input  logic                              mem_req_data_ready,
    input  logic                              mem_resp_valid,
    input  logic [IDX_BITS+TAG_BITS-1:0]      mem_resp_tag,
    input  logic [DATA_BITS-1:0]              mem_resp_data,
    output logic                              resp_err,
    output logic [N_PORTS*32-1:0]             stat_grants
);

    localparam int MASK_BITS = DATA_BITS / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WDATA = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_BITS-1:0]   g_q, g_d;
    logic [IDX_BITS-1:0]   last_q, last_d;
    logic                  resp_err_q, resp_err_d;

    logic [ADDR_BITS-1:0]  addr_a [N_PORTS];
    logic [TAG_BITS-1:0]   tag_a  [N_PORTS];
    logic [DATA_BITS-1:0]  data_a [N_PORTS];
    logic [MASK_BITS-1:0]  mask_a [N_PORTS];

    logic [IDX_BITS-1:0]   pick_s;
    logic [N_PORTS-1:0]    grant_oh_s;
    logic                  sel_valid_s, sel_rw_s, sel_dvalid_s;
    logic                  req_fire_s, data_fire_s, bad_resp_s;
    logic [IDX_BITS-1:0]   resp_idx_s;

    // Unpack the flattened client buses into per-port arrays.
    for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
        assign addr_a[p] = c_req_addr[p*ADDR_BITS +: ADDR_BITS];
        assign tag_a[p]  = c_req_tag[p*TAG_BITS +: TAG_BITS];
        assign data_a[p] = c_req_data_bits[p*DATA_BITS +: DATA_BITS];
        assign mask_a[p] = c_req_data_mask[p*MASK_BITS +: MASK_BITS];
    end

    assign sel_valid_s  = c_req_valid[g_q];
    assign sel_rw_s     = c_req_rw[g_q];
    assign sel_dvalid_s = c_req_data_valid[g_q];
    assign req_fire_s   = (state_q == ST_REQ) && sel_valid_s && mem_req_ready;
    assign data_fire_s  = sel_dvalid_s && mem_req_data_ready;

    // Request/data payload always follows the granted port; valids qualify it.
    assign mem_req_rw        = sel_rw_s;
    assign mem_req_addr      = addr_a[g_q];
    assign mem_req_tag       = {g_q, tag_a[g_q]};
    assign mem_req_data_bits = data_a[g_q];
    assign mem_req_data_mask = mask_a[g_q];

    // Round-robin pick: lowest requester above last, else lowest requester overall.
    always_comb begin
        logic [IDX_BITS-1:0] pick_hi, pick_lo;
        logic                hi_found;
        pick_hi  = '0;
        pick_lo  = '0;
        hi_found = 1'b0;
        for (int p = N_PORTS - 1; p >= 0; p--) begin
            pick_lo  = c_req_valid[p] ? IDX_BITS'(p) : pick_lo;
            pick_hi  = (c_req_valid[p] && (IDX_BITS'(p) > last_q)) ? IDX_BITS'(p) : pick_hi;
            hi_found = hi_found | (c_req_valid[p] && (IDX_BITS'(p) > last_q));
        end
        pick_s = hi_found ? pick_hi : pick_lo;
    end

    // One-hot decode of the granted port index.
    always_comb begin
        grant_oh_s = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            grant_oh_s[p] = (g_q == IDX_BITS'(p));
        end
    end

    // Next-state and handshake outputs of the grant FSM.
    always_comb begin
        state_d            = state_q;
        g_d                = g_q;
        last_d             = last_q;
        mem_req_valid      = 1'b0;
        c_req_ready        = '0;
        mem_req_data_valid = 1'b0;
        c_req_data_ready   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|c_req_valid) begin
                    g_d     = pick_s;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                mem_req_valid = sel_valid_s;
                c_req_ready   = grant_oh_s & {N_PORTS{mem_req_ready}};
                if (sel_rw_s) begin
                    mem_req_data_valid = sel_dvalid_s;
                    c_req_data_ready   = grant_oh_s & {N_PORTS{mem_req_data_ready}};
                end else begin
                    mem_req_data_valid = 1'b0;
                end
                if (req_fire_s) begin
                    last_d = g_q;
                    if (!sel_rw_s || data_fire_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WDATA: begin
                mem_req_data_valid = sel_dvalid_s;
                c_req_data_ready   = grant_oh_s & {N_PORTS{mem_req_data_ready}};
                if (data_fire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WDATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response routing by tag index; out-of-range indices are dropped and flagged.
    always_comb begin
        resp_idx_s   = mem_resp_tag[IDX_BITS+TAG_BITS-1 -: IDX_BITS];
        c_resp_valid = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            c_resp_valid[p] = mem_resp_valid && (resp_idx_s == IDX_BITS'(p));
        end
        bad_resp_s = mem_resp_valid && (32'(resp_idx_s) >= 32'(N_PORTS));
        resp_err_d = resp_err_q | bad_resp_s;
    end

    assign c_resp_tag  = mem_resp_tag[TAG_BITS-1:0];
    assign c_resp_data = mem_resp_data;
    assign resp_err    = resp_err_q;

    // FSM, grant index, round-robin pointer and sticky error register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            g_q        <= '0;
            last_q     <= IDX_BITS'(N_PORTS - 1);
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            last_q     <= last_d;
            resp_err_q <= resp_err_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] grants_q [N_PORTS];
    logic [31:0] grants_d [N_PORTS];

    // Per-port grant counters advance on each accepted request, wrapping at 2^32.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            grants_d[p] = grants_q[p] + ((req_fire_s && grant_oh_s[p]) ? 32'd1 : 32'd0);
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < N_PORTS; p++) begin
                grants_q[p] <= 32'd0;
            end
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                grants_q[p] <= grants_d[p];
            end
        end
    end

    for (genvar p = 0; p < N_PORTS; p++) begin : g_stats
        assign stat_grants[p*32 +: 32] = grants_q[p];
    end
`else
    assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by a randomized run, all
// compared against a transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;

    localparam int NP = 3;
    localparam int IB = 2;
    localparam int AB = 28;
    localparam int DB = 32;
    localparam int TB = 5;
    localparam int MB = DB / 8;
    localparam int MT = IB + TB;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     c_req_valid, c_req_rw, c_req_ready;
    logic [NP*AB-1:0]  c_req_addr;
    logic [NP*TB-1:0]  c_req_tag;
    logic [NP-1:0]     c_req_data_valid, c_req_data_ready;
    logic [NP*DB-1:0]  c_req_data_bits;
    logic [NP*MB-1:0]  c_req_data_mask;
    logic [NP-1:0]     c_resp_valid;
    logic [TB-1:0]     c_resp_tag;
    logic [DB-1:0]     c_resp_data;
    logic              mem_req_valid, mem_req_rw, mem_req_ready;
    logic [AB-1:0]     mem_req_addr;
    logic [MT-1:0]     mem_req_tag;
    logic              mem_req_data_valid, mem_req_data_ready;
    logic [DB-1:0]     mem_req_data_bits;
    logic [MB-1:0]     mem_req_data_mask;
    logic              mem_resp_valid;
    logic [MT-1:0]     mem_resp_tag;
    logic [DB-1:0]     mem_resp_data;
    logic              resp_err;
    logic [NP*32-1:0]  stat_grants;

    mem_port_arbiter #(
        .N_PORTS(NP), .IDX_BITS(IB), .ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB)
    ) dut (
        .clk(clk), .reset(rst),
        .c_req_valid(c_req_valid), .c_req_rw(c_req_rw), .c_req_addr(c_req_addr),
        .c_req_tag(c_req_tag), .c_req_ready(c_req_ready),
        .c_req_data_valid(c_req_data_valid), .c_req_data_bits(c_req_data_bits),
        .c_req_data_mask(c_req_data_mask), .c_req_data_ready(c_req_data_ready),
        .c_resp_valid(c_resp_valid), .c_resp_tag(c_resp_tag), .c_resp_data(c_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_bits(mem_req_data_bits),
        .mem_req_data_mask(mem_req_data_mask), .mem_req_data_ready(mem_req_data_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
        .mem_resp_data(mem_resp_data), .resp_err(resp_err), .stat_grants(stat_grants)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Client intentions: each port has at most one outstanding transaction.
    logic          cl_pend [NP];
    logic          cl_rw   [NP];
    logic          cl_reqd [NP];
    logic          cl_datd [NP];
    logic [AB-1:0] cl_addr [NP];
    logic [TB-1:0] cl_tag  [NP];
    logic [DB-1:0] cl_data [NP];
    logic [MB-1:0] cl_mask [NP];

    // Reference model: which port owns the downstream port, and whether only
    // its write beat is still owed.
    int          m_owner;
    int          m_last;
    bit          m_wait;
    bit          m_err;
    logic [31:0] m_grants [NP];

    logic [IB-1:0] order [$];

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = NP - 1;
        m_wait  = 1'b0;
        m_err   = 1'b0;
        for (int p = 0; p < NP; p++) m_grants[p] = 32'd0;
    endtask

    task automatic clear_clients();
        for (int p = 0; p < NP; p++) begin
            cl_pend[p] = 1'b0; cl_rw[p] = 1'b0; cl_reqd[p] = 1'b0; cl_datd[p] = 1'b0;
            cl_addr[p] = '0; cl_tag[p] = '0; cl_data[p] = '0; cl_mask[p] = '0;
        end
    endtask

    task automatic post(input int p, input logic rw, input logic [AB-1:0] addr, input logic [TB-1:0] tag);
        cl_pend[p] = 1'b1; cl_reqd[p] = 1'b0; cl_datd[p] = 1'b0;
        cl_rw[p] = rw; cl_addr[p] = addr; cl_tag[p] = tag;
        cl_data[p] = DB'($urandom); cl_mask[p] = MB'($urandom);
    endtask

    task automatic drive_pack();
        for (int p = 0; p < NP; p++) begin
            c_req_valid[p]               = cl_pend[p] & ~cl_reqd[p];
            c_req_rw[p]                  = cl_rw[p];
            c_req_addr[p*AB +: AB]       = cl_addr[p];
            c_req_tag[p*TB +: TB]        = cl_tag[p];
            c_req_data_valid[p]          = cl_pend[p] & cl_rw[p] & ~cl_datd[p];
            c_req_data_bits[p*DB +: DB]  = cl_data[p];
            c_req_data_mask[p*MB +: MB]  = cl_mask[p];
        end
    endtask

    task automatic peek();
        drive_pack();
        #1;
    endtask

    function automatic logic [127:0] exp_stats();
        logic [127:0] v;
        v = '0;
`ifdef MEM_ARB_STATS_EN
        for (int p = 0; p < NP; p++) v[p*32 +: 32] = m_grants[p];
`endif
        return v;
    endfunction

    // One clock cycle: check all outputs against the model, then advance it.
    task automatic tick();
        logic [NP-1:0] e_crdy, e_cdrdy, e_rvalid;
        logic          e_mv, e_mdv;
        int            o, idx;
        bit            found;
        drive_pack();
        #1;
        if (rst) model_reset();
        e_crdy = '0; e_cdrdy = '0; e_mv = 1'b0; e_mdv = 1'b0;
        o = m_owner;
        if (o >= 0) begin
            if (!m_wait) begin
                e_mv      = c_req_valid[o];
                e_crdy[o] = mem_req_ready;
            end
            if (m_wait || cl_rw[o]) begin
                e_mdv      = c_req_data_valid[o];
                e_cdrdy[o] = mem_req_data_ready;
            end
        end
        idx = int'(mem_resp_tag[MT-1 -: IB]);
        for (int q = 0; q < NP; q++) e_rvalid[q] = mem_resp_valid && (idx == q);

        chk("c_req_ready",        128'(c_req_ready),        128'(e_crdy));
        chk("mem_req_valid",      128'(mem_req_valid),      128'(e_mv));
        chk("mem_req_data_valid", 128'(mem_req_data_valid), 128'(e_mdv));
        chk("c_req_data_ready",   128'(c_req_data_ready),   128'(e_cdrdy));
        chk("c_resp_valid",       128'(c_resp_valid),       128'(e_rvalid));
        chk("c_resp_tag",         128'(c_resp_tag),         128'(mem_resp_tag[TB-1:0]));
        chk("c_resp_data",        128'(c_resp_data),        128'(mem_resp_data));
        chk("resp_err",           128'(resp_err),           128'(m_err));
        chk("stat_grants",        128'(stat_grants),        exp_stats());
        if (e_mv) begin
            chk("mem_req_tag",  128'(mem_req_tag),  128'({IB'(o), cl_tag[o]}));
            chk("mem_req_addr", 128'(mem_req_addr), 128'(cl_addr[o]));
            chk("mem_req_rw",   128'(mem_req_rw),   128'(cl_rw[o]));
        end
        if (e_mdv) begin
            chk("mem_req_data_bits", 128'(mem_req_data_bits), 128'(cl_data[o]));
            chk("mem_req_data_mask", 128'(mem_req_data_mask), 128'(cl_mask[o]));
        end

        if (!rst) begin
            if (mem_resp_valid && idx >= NP) m_err = 1'b1;
            if (o < 0) begin
                found = 1'b0;
                for (int k = 1; k <= NP; k++) begin
                    if (!found && c_req_valid[(m_last + k) % NP]) begin
                        found   = 1'b1;
                        m_owner = (m_last + k) % NP;
                        m_wait  = 1'b0;
                    end
                end
            end else if (!m_wait) begin
                if (c_req_valid[o] && mem_req_ready) begin
                    m_last      = o;
                    m_grants[o] = m_grants[o] + 32'd1;
                    if (!cl_rw[o] || (c_req_data_valid[o] && mem_req_data_ready)) m_owner = -1;
                    else m_wait = 1'b1;
                end
            end else begin
                if (c_req_data_valid[o] && mem_req_data_ready) begin
                    m_owner = -1;
                    m_wait  = 1'b0;
                end
            end
        end

        for (int p = 0; p < NP; p++) begin
            if (c_req_valid[p] && c_req_ready[p]) cl_reqd[p] = 1'b1;
            if (c_req_data_valid[p] && c_req_data_ready[p]) cl_datd[p] = 1'b1;
            if (cl_pend[p] && cl_reqd[p] && (!cl_rw[p] || cl_datd[p])) cl_pend[p] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_clients();
        mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [127:0] st;
        rst = 1'b1;
        clear_clients();
        model_reset();
        mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
        drive_pack();
        @(negedge clk);
        do_reset();

        // Single read from port 0: presented one cycle after IDLE, then back to IDLE.
        post(0, 1'b0, 28'h10, 5'd3);
        mem_req_ready = 1'b1;
        tick();
        peek();
        chk("rd_valid_c1", 128'(mem_req_valid), 128'(1'b1));
        chk("rd_tag_c1",   128'(mem_req_tag),   128'(7'h03));
        chk("rd_addr_c1",  128'(mem_req_addr),  128'(28'h10));
        tick();
        peek();
        chk("rd_idle_c2",  128'(mem_req_valid), 128'(1'b0));
        tick();

        // Two ports requesting continuously alternate 0,1,0,1.
        do_reset();
        mem_req_ready = 1'b1;
        order.delete();
        for (int c = 0; c < 8; c++) begin
            if (!cl_pend[0]) post(0, 1'b0, AB'($urandom), TB'($urandom));
            if (!cl_pend[1]) post(1, 1'b0, AB'($urandom), TB'($urandom));
            peek();
            if (mem_req_valid && mem_req_ready) order.push_back(mem_req_tag[MT-1 -: IB]);
            tick();
        end
        chk("rr_count", 128'(order.size()), 128'(4));
        for (int i = 0; i < order.size(); i++) chk("rr_order", 128'(order[i]), 128'(i % 2));
        peek();
        st = '0;
`ifdef MEM_ARB_STATS_EN
        st = 128'({32'd0, 32'd2, 32'd2});
`endif
        chk("rr_stats", 128'(stat_grants), st);
        clear_clients();
        tick();

        // Port 1 write with both readies: request and beat in one cycle, no WDATA.
        do_reset();
        post(1, 1'b1, AB'($urandom), TB'($urandom));
        mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
        tick();
        peek();
        chk("wr1_req_ready",  128'(c_req_ready),        128'(3'b010));
        chk("wr1_data_valid", 128'(mem_req_data_valid), 128'(1'b1));
        chk("wr1_data_ready", 128'(c_req_data_ready),   128'(3'b010));
        tick();
        post(0, 1'b0, AB'($urandom), TB'($urandom));
        tick();
        peek();
        chk("wr1_next_valid", 128'(mem_req_valid), 128'(1'b1));
        chk("wr1_next_idx",   128'(mem_req_tag[MT-1 -: IB]), 128'(2'd0));
        tick();

        // Port 0 write stalls in WDATA for 3 cycles; port 1 must wait.
        do_reset();
        post(0, 1'b1, AB'($urandom), TB'($urandom));
        post(1, 1'b0, AB'($urandom), TB'($urandom));
        mem_req_ready = 1'b1; mem_req_data_ready = 1'b0;
        tick();
        tick();
        for (int c = 0; c < 3; c++) begin
            peek();
            chk("wd_hold_mvalid", 128'(mem_req_valid),      128'(1'b0));
            chk("wd_hold_cready", 128'(c_req_ready),        128'(3'b000));
            chk("wd_hold_dvalid", 128'(mem_req_data_valid), 128'(1'b1));
            tick();
        end
        mem_req_data_ready = 1'b1;
        tick();
        tick();
        peek();
        chk("wd_p1_valid", 128'(mem_req_valid), 128'(1'b1));
        chk("wd_p1_idx",   128'(mem_req_tag[MT-1 -: IB]), 128'(2'd1));
        tick();

        // Response with index 3 on a 3-port arbiter: dropped, sticky error.
        do_reset();
        mem_resp_valid = 1'b1; mem_resp_tag = {2'd3, 5'd7}; mem_resp_data = 32'hCAFE0001;
        peek();
        chk("bad_resp_valid", 128'(c_resp_valid), 128'(3'b000));
        tick();
        mem_resp_valid = 1'b0;
        peek();
        chk("bad_resp_err", 128'(resp_err), 128'(1'b1));
        tick(); tick(); tick();
        peek();
        chk("bad_resp_sticky", 128'(resp_err), 128'(1'b1));
        rst = 1'b1;
        #1;
        chk("bad_resp_cleared", 128'(resp_err), 128'(1'b0));
        do_reset();

        // Reset in WDATA: outputs drop at once, write is abandoned, port 0 wins next.
        post(0, 1'b1, AB'($urandom), TB'($urandom));
        mem_req_ready = 1'b1; mem_req_data_ready = 1'b0;
        tick();
        tick();
        mem_req_data_ready = 1'b1;
        peek();
        chk("rst_wd_pre_dready", 128'(c_req_data_ready), 128'(3'b001));
        rst = 1'b1;
        #1;
        chk("rst_wd_dvalid", 128'(mem_req_data_valid), 128'(1'b0));
        chk("rst_wd_dready", 128'(c_req_data_ready),   128'(3'b000));
        chk("rst_wd_mvalid", 128'(mem_req_valid),      128'(1'b0));
        chk("rst_wd_stats",  128'(stat_grants),        128'(0));
        tick();
        rst = 1'b0;
        tick();
        peek();
        chk("rst_wd_no_beat", 128'(mem_req_data_valid), 128'(1'b0));
        tick();
        clear_clients();
        post(0, 1'b0, AB'($urandom), TB'($urandom));
        post(1, 1'b0, AB'($urandom), TB'($urandom));
        tick();
        peek();
        chk("rst_first_idx", 128'(mem_req_tag[MT-1 -: IB]), 128'(2'd0));
        tick();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!cl_pend[p] && $urandom_range(0, 2) == 0)
                    post(p, 1'($urandom), AB'($urandom), TB'($urandom));
            end
            mem_req_ready      = 1'($urandom);
            mem_req_data_ready = (mem_req_ready || m_wait) ? 1'($urandom) : 1'b0;
            mem_resp_valid     = ($urandom_range(0, 3) == 0);
            mem_resp_tag       = {($urandom_range(0, 99) == 0) ? 2'd3 : IB'($urandom_range(0, 2)),
                                  TB'($urandom)};
            mem_resp_data      = DB'($urandom);
            if ($urandom_range(0, 599) == 0) do_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, meaning number of client ports (2..8).
REQ-002 SHALL have parameter IDX_BITS, default 1, meaning port-index width, equal to ceil(log2(N_PORTS)).
REQ-003 SHALL have parameter ADDR_BITS, default 28, meaning memory request address width.
REQ-004 SHALL have parameter DATA_BITS, default 128, meaning data width of one beat.
REQ-005 SHALL have parameter TAG_BITS, default 5, meaning client tag width.
REQ-006 SHALL have clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have the per-client request inputs c_req_valid [N_PORTS], c_req_rw [N_PORTS], c_req_addr [N_PORTS*ADDR_BITS] and c_req_tag [N_PORTS*TAG_BITS], flattened with port 0 in the LSBs.
REQ-009 SHALL have the per-client request output c_req_ready [N_PORTS], one-hot or zero.
REQ-010 SHALL have the per-client write-data inputs c_req_data_valid [N_PORTS], c_req_data_bits [N_PORTS*DATA_BITS] and c_req_data_mask [N_PORTS*DATA_BITS/8].
REQ-011 SHALL have the per-client write-data output c_req_data_ready [N_PORTS].
REQ-012 SHALL have the client response outputs c_resp_valid [N_PORTS] (one-hot or zero), c_resp_tag [TAG_BITS] (broadcast) and c_resp_data [DATA_BITS] (broadcast).
REQ-013 SHALL have the downstream request outputs mem_req_valid 1, mem_req_rw 1, mem_req_addr ADDR_BITS and mem_req_tag IDX_BITS+TAG_BITS, plus the input mem_req_ready 1.
REQ-014 SHALL have the downstream write-data outputs mem_req_data_valid 1, mem_req_data_bits DATA_BITS and mem_req_data_mask DATA_BITS/8, plus the input mem_req_data_ready 1.
REQ-015 SHALL have the downstream response inputs mem_resp_valid 1, mem_resp_tag IDX_BITS+TAG_BITS and mem_resp_data DATA_BITS.
REQ-016 SHALL have the outputs resp_err 1 (sticky bad-response-index flag) and stat_grants N_PORTS*32 (per-port grant counters).

Function
REQ-017 SHALL implement a three-state FSM with states IDLE, REQ and WDATA, plus a registered grant index g and a round-robin pointer last.
REQ-018 SHALL, in IDLE when any c_req_valid is set, latch g as the first requesting port after last (modulo N_PORTS) and move to REQ; otherwise it stays in IDLE.
REQ-019 SHALL, in REQ, drive mem_req_valid = c_req_valid[g], forward rw and addr, drive mem_req_tag = {g, c_req_tag[g]}, and drive c_req_ready[g] = mem_req_ready.
REQ-020 SHALL, on a REQ handshake, set last = g and increment stat_grants[g].
REQ-021 SHALL, on a REQ handshake for a read, move to IDLE.
REQ-022 SHALL, on a REQ handshake for a write, move to WDATA, or go straight to IDLE if the data beat also completes in the same cycle.
REQ-023 SHALL forward the write-data channel of port g only in REQ-with-rw=1 and in WDATA; c_req_data_ready[g] = mem_req_data_ready there and 0 everywhere else.
REQ-024 SHALL, in WDATA, move to IDLE on the data handshake.
REQ-025 SHALL ensure minimum request latency is 1 cycle (valid in IDLE, presented downstream next cycle) and peak throughput is 1 request per 2 cycles.
REQ-026 SHALL hold g stable from IDLE exit until the return to IDLE; a client dropping valid before ready is a protocol violation with undefined result.
REQ-027 SHALL route responses combinationally with no backpressure: idx = mem_resp_tag upper IDX_BITS, c_resp_valid[idx] = mem_resp_valid, c_resp_tag = lower TAG_BITS.
REQ-028 SHALL, when mem_resp_valid is set with idx >= N_PORTS, drop the response and set resp_err, which stays set until reset.
REQ-029 SHALL route responses independently of the request FSM, including when a response arrives in the same cycle as a grant.
REQ-030 SHALL make stat_grants counters wrap from 2^32-1 to 0.

Reset
REQ-031 SHALL, on reset assertion, immediately force the FSM to IDLE, g = 0, last = N_PORTS-1 (port 0 wins first), resp_err = 0 and stat_grants = 0.
REQ-032 SHALL hold all ready and valid outputs at 0 during reset, except c_resp_valid, which follows mem_resp_valid.
REQ-033 SHALL, on reset mid-write, abandon the write; no data beat is issued after deassertion.

Configuration
REQ-034 SHALL use the macro MEM_ARB_STATS_EN.
REQ-035 SHALL, with MEM_ARB_STATS_EN defined, implement stat_grants as specified in REQ-020 and REQ-030.
REQ-036 SHALL, without MEM_ARB_STATS_EN, keep the stat_grants port but tie it to 0 and infer no counter flops.

Verification
REQ-037 SHALL cover: port0 read addr 0x10 tag 3, mem_req_ready=1 -> mem_req_valid in cycle 1, mem_req_tag=0x03, back to IDLE in cycle 2.
REQ-038 SHALL cover: both ports requesting continuously after reset -> grant order 0,1,0,1; stat_grants = {2,2} after 4 grants.
REQ-039 SHALL cover: port1 write with data valid and both readies high -> request and data complete in the same cycle, FSM returns to IDLE, no WDATA state.
REQ-040 SHALL cover: port0 write, mem_req_data_ready low for 3 cycles -> FSM holds WDATA, port1 request is not granted until the data fires.
REQ-041 SHALL cover: N_PORTS=3, mem_resp_tag = {idx=3, tag=7} -> all c_resp_valid = 0, resp_err = 1 until reset.
REQ-042 SHALL cover: reset asserted in WDATA -> outputs go to 0 asynchronously, stat_grants = 0, first grant after release goes to port 0.
